// File: rtl/dm_scanctl.sv
// Scan-chain access controller: capture, WIDTH-bit serial shift (write or recirculating read), response.
// Optional DM_SCAN_ABORT_EN adds AbortReq to cut a CAPTURE/SHIFT short with an error response.
//
// state   | meaning
// IDLE    | ready for a request
// CAPTURE | one-cycle ScanLoad pulse into the chain
// SHIFT   | WIDTH cycles of ScanEn, chain tail shifted into shreg
// RESP    | response held until RspReady
module dm_scanctl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [WIDTH-1:0] ReqData,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspErr,
    output logic             ScanLoad,
    output logic             ScanEn,
    output logic             ScanOut,
    input  logic             ScanIn,
    output logic             Busy
`ifdef DM_SCAN_ABORT_EN
    ,
    input  logic             AbortReq
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] SHIFT   = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic             err_q, err_d;
    logic             abort_req;

`ifdef DM_SCAN_ABORT_EN
    assign abort_req = AbortReq;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    state_d = CAPTURE;
                    shreg_d = ReqData;
                    wr_d    = ReqWrite;
                    cnt_d   = CNT_INIT;
                    err_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (abort_req) begin
                    state_d = RESP;
                    shreg_d = '0;
                    err_d   = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_req) begin
                    state_d = RESP;
                    shreg_d = '0;
                    err_d   = 1'b1;
                end else begin
                    shreg_d = {ScanIn, shreg_q[WIDTH-1:1]};
                    if (cnt_q == '0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RESP: begin
                // no acceptance here: IDLE must be visited before the next request
                if (RspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    assign ReqReady = (state_q == IDLE);
    assign Busy     = (state_q != IDLE);
    assign ScanLoad = (state_q == CAPTURE);
    assign ScanEn   = (state_q == SHIFT);
    // read requests recirculate the tail straight back into the head
    assign ScanOut  = (state_q == SHIFT) ? (wr_q ? shreg_q[0] : ScanIn) : 1'b0;
    assign RspValid = (state_q == RESP);
    assign RspData  = shreg_q;
    assign RspErr   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dm_scanctl.sv
// Self-checking bench for dm_scanctl (WIDTH=8) with a behavioural scan-chain model.
module tb_dm_scanctl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ReqValid = 1'b0;
    logic         ReqReady;
    logic         ReqWrite = 1'b0;
    logic [W-1:0] ReqData = '0;
    logic         RspValid;
    logic         RspReady = 1'b0;
    logic [W-1:0] RspData;
    logic         RspErr;
    logic         ScanLoad;
    logic         ScanEn;
    logic         ScanOut;
    logic         ScanIn;
    logic         Busy;
`ifdef DM_SCAN_ABORT_EN
    logic         AbortReq = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // chain model: capture loads cap_val, shift moves head->tail, tail bit 0 feeds ScanIn
    logic [W-1:0] chain = '0;
    logic [W-1:0] cap_val = '0;
    int load_cnt = 0;
    int en_cnt = 0;

    assign ScanIn = chain[0];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ScanLoad) chain <= cap_val;
        else if (ScanEn) chain <= {ScanOut, chain[W-1:1]};
    end

    always @(negedge clk) begin
        if (ScanLoad) load_cnt++;
        if (ScanEn) en_cnt++;
        if (ScanLoad && ScanEn) begin
            errors++;
            $display("FAIL load_en_overlap ScanLoad=%0b ScanEn=%0b required not both 1", ScanLoad, ScanEn);
        end
    end

    dm_scanctl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqData(ReqData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
        .ScanLoad(ScanLoad), .ScanEn(ScanEn), .ScanOut(ScanOut), .ScanIn(ScanIn),
        .Busy(Busy)
`ifdef DM_SCAN_ABORT_EN
        , .AbortReq(AbortReq)
`endif
    );

    int load0, en0;

    task automatic start_req(input logic wr, input logic [W-1:0] data, input logic [W-1:0] cap);
        int n = 0;
        cap_val = cap;
        @(negedge clk);
        ReqValid = 1'b1; ReqWrite = wr; ReqData = data;
        while (!ReqReady && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        ReqWrite = 1'($urandom);
        ReqData  = W'($urandom);
        load0 = load_cnt; en0 = en_cnt;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!RspValid && lat < 200);
    endtask

    task automatic handshake();
        @(negedge clk);
        RspReady = 1'b1;
        @(posedge clk);
        #1 RspReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ReqReady, RspValid, RspErr, ScanLoad, ScanEn, ScanOut, Busy} !== 7'b1000000 || RspData !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy/vld/err/ld/en/so/busy=%b data=%h required 1000000 00",
                     {ReqReady, RspValid, RspErr, ScanLoad, ScanEn, ScanOut, Busy}, RspData);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ReqReady !== 1'b1 || Busy !== 1'b0 || RspValid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got rdy=%b busy=%b vld=%b required 1 0 0", ReqReady, Busy, RspValid);
        end
    endtask

    // one full transaction against the model; hold = cycles RspReady stays low in RESP
    task automatic run_txn(input string name, input logic wr, input logic [W-1:0] data,
                           input logic [W-1:0] cap, input int hold);
        int lat;
        logic [W-1:0] exp_chain;
        exp_chain = wr ? data : cap;
        start_req(wr, data, cap);
        wait_resp(lat);
        checks++;
        if (lat !== W + 2) begin
            errors++;
            $display("FAIL %s latency got %0d required %0d", name, lat, W + 2);
        end
        checks++;
        if (load_cnt - load0 !== 1 || en_cnt - en0 !== W) begin
            errors++;
            $display("FAIL %s scan_counts got load=%0d en=%0d required 1 %0d", name, load_cnt - load0, en_cnt - en0, W);
        end
        checks++;
        if (RspData !== cap || RspErr !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp got data=%h err=%b required %h 0", name, RspData, RspErr, cap);
        end
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'(i % 2);
            ReqData  = W'($urandom);
            ReqWrite = 1'($urandom);
            @(negedge clk);
            checks++;
            if (RspValid !== 1'b1 || RspData !== cap || ReqReady !== 1'b0 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold%0d got vld=%b data=%h rdy=%b busy=%b required 1 %h 0 1",
                         name, i, RspValid, RspData, ReqReady, Busy, cap);
            end
        end
        ReqValid = 1'b0;
        handshake();
        @(negedge clk);
        checks++;
        if (chain !== exp_chain || ReqReady !== 1'b1 || RspValid !== 1'b0) begin
            errors++;
            $display("FAIL %s after got chain=%h rdy=%b vld=%b required %h 1 0", name, chain, ReqReady, RspValid, exp_chain);
        end
    endtask

    task automatic test_read();
        run_txn("read_a5", 1'b0, 8'h5A, 8'hA5, 0);
    endtask

    task automatic test_write();
        run_txn("write_81", 1'b1, 8'h81, 8'h3C, 0);
    endtask

    task automatic test_hold();
        run_txn("hold5", 1'b0, 8'h00, 8'hC3, 5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_txn($sformatf("rand%0d", k), 1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_shift();
        int n = 0;
        start_req(1'b1, 8'hF0, 8'h0F);
        do begin @(negedge clk); n++; end while (en_cnt - en0 < 4 && n < 50);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({ReqReady, RspValid, RspErr, ScanLoad, ScanEn, ScanOut, Busy} !== 7'b1000000 || RspData !== '0) begin
            errors++;
            $display("FAIL midshift_reset got rdy/vld/err/ld/en/so/busy=%b data=%h required 1000000 00",
                     {ReqReady, RspValid, RspErr, ScanLoad, ScanEn, ScanOut, Busy}, RspData);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (RspValid !== 1'b0 || Busy !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL midshift_no_rsp got %0d busy/valid cycles required 0", n);
        end
        run_txn("after_reset", 1'b0, 8'h00, 8'h69, 1);
    endtask

    task automatic test_back_to_back();
        int lat;
        start_req(1'b1, 8'h96, 8'h11);
        wait_resp(lat);
        cap_val = 8'hE7;
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqData = 8'h00; RspReady = 1'b1;
        @(posedge clk);
        #1 RspReady = 1'b0;
        @(negedge clk);
        checks++;
        if (ReqReady !== 1'b1 || ScanLoad !== 1'b0 || chain !== 8'h96) begin
            errors++;
            $display("FAIL b2b_idle got rdy=%b load=%b chain=%h required 1 0 96", ReqReady, ScanLoad, chain);
        end
        @(posedge clk);
        #1;
        ReqValid = 1'b0;
        load0 = load_cnt; en0 = en_cnt;
        checks++;
        if (ScanLoad !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got load=%b required 1", ScanLoad);
        end
        wait_resp(lat);
        checks++;
        if (lat !== W + 2 || RspData !== 8'hE7) begin
            errors++;
            $display("FAIL b2b_second got lat=%0d data=%h required %0d e7", lat, RspData, W + 2);
        end
        handshake();
        @(negedge clk);
        checks++;
        if (chain !== 8'hE7) begin
            errors++;
            $display("FAIL b2b_chain got %h required e7", chain);
        end
    endtask

`ifdef DM_SCAN_ABORT_EN
    task automatic test_abort();
        int n = 0;
        @(negedge clk);
        AbortReq = 1'b1;
        @(negedge clk);
        AbortReq = 1'b0;
        checks++;
        if (ReqReady !== 1'b1 || Busy !== 1'b0 || RspValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got rdy=%b busy=%b vld=%b required 1 0 0", ReqReady, Busy, RspValid);
        end
        start_req(1'b1, 8'h55, 8'hAA);
        do begin @(negedge clk); n++; end while (en_cnt - en0 < 3 && n < 50);
        AbortReq = 1'b1;
        @(posedge clk);
        #1 AbortReq = 1'b0;
        checks++;
        if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspData !== '0 || ScanEn !== 1'b0) begin
            errors++;
            $display("FAIL abort_shift got vld=%b err=%b data=%h en=%b required 1 1 00 0", RspValid, RspErr, RspData, ScanEn);
        end
        handshake();
        run_txn("after_abort", 1'b0, 8'h00, 8'h3B, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_hold();
        test_reset_mid_shift();
        test_back_to_back();
`ifdef DM_SCAN_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
